braun_prod_accum: RTL and testbench

//  Downstream consumer of the 4x4 Braun multiplier's 8-bit product.

---
 rtl/braun_prod_accum.sv | 118 +++++++++++
 tb/tb_braun_prod_accum.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/braun_prod_accum.sv
// Streaming accumulator for Braun multiplier products: sums LEN products per frame
// and holds each frame sum, with a sticky overflow flag, until downstream takes it.
module braun_prod_accum #(
    parameter int PW  = 8,
    parameter int AW  = 16,
    parameter int LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [PW-1:0] p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf
);

    localparam int CW = $clog2(LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic          out_ovf_q, out_ovf_d;
    logic [AW:0]   sum_s;

    // One extra bit so the carry out of the accumulator can feed the overflow flag.
    assign sum_s = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, p};

    assign p_ready   = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

    // Next-state logic for frame accumulation and result handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (clear) begin
                    acc_d     = {AW{1'b0}};
                    cnt_d     = {CW{1'b0}};
                    ovf_acc_d = 1'b0;
                end else if (p_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        out_sum_d   = sum_s[AW-1:0];
                        out_ovf_d   = ovf_acc_q | sum_s[AW];
                        out_valid_d = 1'b1;
                        acc_d       = {AW{1'b0}};
                        cnt_d       = {CW{1'b0}};
                        ovf_acc_d   = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d     = sum_s[AW-1:0];
                        cnt_d     = cnt_q + CW'(1);
                        ovf_acc_d = ovf_acc_q | sum_s[AW];
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_HOLD: begin
                // clear is ignored here: the held result must never be lost.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_ACC;
                acc_d       = {AW{1'b0}};
                cnt_d       = {CW{1'b0}};
                ovf_acc_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= {AW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {AW{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_braun_prod_accum.sv
// Bench for braun_prod_accum: AW=16 and AW=9 instances share one LEN=4 stimulus
// stream; a LEN=3 instance runs a randomized handshake run. Expected frames are queued.
module tb_braun_prod_accum;

    typedef struct packed {
        logic [15:0] s;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        p_valid;
    logic [7:0]  p;
    logic        out_ready;
    logic        a_p_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_sum;
    logic        b_p_ready, b_out_valid, b_out_ovf;
    logic [8:0]  b_out_sum;
    logic        c_p_valid, c_out_ready;
    logic [7:0]  c_p;
    logic        c_p_ready, c_out_valid, c_out_ovf;
    logic [15:0] c_out_sum;

    int   tests;
    int   fails;
    logic hold_m;
    int   tot_m;
    int   cnt_m;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    braun_prod_accum #(.PW(8), .AW(16), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .p_valid(p_valid), .p_ready(a_p_ready),
        .p(p), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_ovf(a_out_ovf)
    );

    braun_prod_accum #(.PW(8), .AW(9), .LEN(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .p_valid(p_valid), .p_ready(b_p_ready),
        .p(p), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_ovf(b_out_ovf)
    );

    braun_prod_accum #(.PW(8), .AW(16), .LEN(3)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .p_valid(c_p_valid), .p_ready(c_p_ready),
        .p(c_p), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum),
        .out_ovf(c_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle on the shared A/B stream: drive, check at negedge, update model.
    task automatic step_ab(input logic v, input logic [7:0] pv, input logic rdy,
                           input logic clr, input logic r);
        exp_t e;
        p_valid = v; p = pv; out_ready = rdy; clear = clr; rst = r;
        @(negedge clk);
        chk("a_p_ready", {31'd0, a_p_ready}, {31'd0, !hold_m});
        chk("b_p_ready", {31'd0, b_p_ready}, {31'd0, !hold_m});
        chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, hold_m});
        chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, hold_m});
        if (r) begin
            hold_m = 1'b0; tot_m = 0; cnt_m = 0;
            qa.delete(); qb.delete();
        end else if (hold_m) begin
            if (rdy) begin
                chk("a_qsize", qa.size(), 32'd1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_out_sum", {16'd0, a_out_sum}, {16'd0, e.s});
                    chk("a_out_ovf", {31'd0, a_out_ovf}, {31'd0, e.o});
                end
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_out_sum", {23'd0, b_out_sum}, {16'd0, e.s});
                    chk("b_out_ovf", {31'd0, b_out_ovf}, {31'd0, e.o});
                end
                hold_m = 1'b0;
            end
        end else if (clr) begin
            tot_m = 0; cnt_m = 0;
        end else if (v) begin
            tot_m += int'(pv);
            cnt_m++;
            if (cnt_m == 4) begin
                e.s = 16'(tot_m % 65536); e.o = (tot_m > 65535); qa.push_back(e);
                e.s = 16'(tot_m % 512);   e.o = (tot_m > 511);   qb.push_back(e);
                tot_m = 0; cnt_m = 0; hold_m = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   frames;
        int   cyc;
        int   tot_c;
        int   cnt_c;
        logic hold_c;
        exp_t e;

        tests = 0; fails = 0;
        hold_m = 1'b0; tot_m = 0; cnt_m = 0;
        rst = 1'b1; clear = 1'b0; p_valid = 1'b0; p = 8'd0; out_ready = 1'b0;
        c_p_valid = 1'b0; c_p = 8'd0; c_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, a_out_sum}, 32'd0);
        chk("rst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
        chk("rst_p_ready", {31'd0, a_p_ready}, 32'd1);

        // 225 x4 back-to-back: 900 in 16 bits, 388 with overflow in 9 bits.
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd225, 1'b1, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        // Overflow flag must not carry into the next frame.
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: result held, beats refused, clear ignored while holding.
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_ab(1'b1, 8'd77, 1'b0, (i == 2), 1'b0);
            chk("bp_out_sum", {16'd0, a_out_sum}, 32'd40);
        end
        step_ab(1'b1, 8'd77, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Clear drops the partial frame and the product presented with it.
        step_ab(1'b1, 8'd50, 1'b1, 1'b0, 1'b0);
        step_ab(1'b1, 8'd60, 1'b1, 1'b0, 1'b0);
        step_ab(1'b1, 8'd99, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame, then a clean frame of 2s.
        step_ab(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        step_ab(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        step_ab(1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mid_rst_out_sum", {16'd0, a_out_sum}, 32'd0);
        chk("mid_rst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
        chk("mid_rst_p_ready", {31'd0, a_p_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Reset while holding a result.
        for (int i = 0; i < 4; i++) step_ab(1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
        step_ab(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("hold_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("hold_rst_out_sum", {16'd0, a_out_sum}, 32'd0);
        step_ab(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Randomized handshakes on the LEN=3 instance.
        frames = 0; cyc = 0; tot_c = 0; cnt_c = 0; hold_c = 1'b0;
        while (frames < 1000 && cyc < 20000) begin
            c_p_valid   = ($urandom_range(3) != 0);
            c_p         = 8'($urandom_range(255));
            c_out_ready = 1'($urandom_range(1));
            @(negedge clk);
            chk("c_p_ready", {31'd0, c_p_ready}, {31'd0, !hold_c});
            chk("c_out_valid", {31'd0, c_out_valid}, {31'd0, hold_c});
            if (hold_c) begin
                if (c_out_ready) begin
                    chk("c_qsize", qc.size(), 32'd1);
                    if (qc.size() > 0) begin
                        e = qc.pop_front();
                        chk("c_out_sum", {16'd0, c_out_sum}, {16'd0, e.s});
                        chk("c_out_ovf", {31'd0, c_out_ovf}, {31'd0, e.o});
                    end
                    frames++;
                    hold_c = 1'b0;
                end
            end else if (c_p_valid) begin
                tot_c += int'(c_p);
                cnt_c++;
                if (cnt_c == 3) begin
                    e.s = 16'(tot_c % 65536); e.o = (tot_c > 65535); qc.push_back(e);
                    tot_c = 0; cnt_c = 0; hold_c = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("c_frames", frames, 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
